// File: rtl/lw_ou.sv
// rtl/lw_ou.sv - word-load operation unit: adds two operands into an address and loads through the LSQ
// One load in flight; the valid/ack handshakes on both sides let it chain ahead of other OUs.
module lw_ou #(
  parameter int         XLEN     = 32,
  parameter logic [2:0] LOAD_FN3 = 3'b010
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] data_in1,
  input  logic [XLEN-1:0] data_in2,
  input  logic            data_valid_in1,
  input  logic            data_valid_in2,
  output logic            data_in_ack1,
  output logic            data_in_ack2,
  output logic            uses_data_in1,
  output logic            uses_data_in2,
  output logic [XLEN-1:0] data_out,
  output logic            data_valid_out,
  input  logic            data_out_ack,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] data,
  output logic [2:0]      fn3,
  output logic            load,
  output logic            store,
  output logic            new_request,
  input  logic            lsq_full,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_complete
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] w_sum;
  logic            w_take;

  assign w_sum = data_in1 + data_in2;

  assign uses_data_in1 = 1'b1;
  assign uses_data_in2 = 1'b1;
  assign data          = '0;
  assign store         = 1'b0;
  assign fn3           = LOAD_FN3;
  assign addr          = r_addr;
  assign data_out      = r_data;

  // Outputs are masked during reset so nothing is consumed or requested in that cycle.
  always_comb begin
    w_next         = r_state;
    w_take         = 1'b0;
    new_request    = 1'b0;
    load           = 1'b0;
    data_valid_out = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_valid_in1 && data_valid_in2 && !rst) begin
          w_take = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        new_request = !rst;
        load        = !rst;
        if (!lsq_full) w_next = WAIT;
      end
      WAIT: begin
        if (load_complete) w_next = RESULT;
      end
      RESULT: begin
        data_valid_out = !rst;
        if (data_out_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign data_in_ack1 = w_take;
  assign data_in_ack2 = w_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) r_addr <= w_sum;
      if (r_state == WAIT && load_complete) r_data <= load_data;
    end
  end

endmodule
